// File: rtl/ysyx_25040129_clint_pkg.sv
// Shared constants and types for the CLINT real-time-counter port:
// bus address window, response codes, register offsets and decode helper.
package ysyx_25040129_clint_pkg;

  localparam logic [31:0] RTC_PORT_ADDR = 32'ha000_0048;
  localparam logic [31:0] RTC_PORT_SIZE = 32'h0000_0008;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_0004;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  typedef enum logic [1:0] {
    SEL_LO  = 2'd0,
    SEL_HI  = 2'd1,
    SEL_ERR = 2'd2
  } clint_sel_e;

  // Offsets are relative to RTC_PORT_ADDR; anything not exactly 0x0/0x4 inside
  // the window (misaligned, or outside the port after wrap) is an error.
  function automatic clint_sel_e decode_offset(input logic [31:0] offset);
    if (offset < RTC_PORT_SIZE) begin
      if (offset == OFF_MTIME_LO) return SEL_LO;
      if (offset == OFF_MTIME_HI) return SEL_HI;
    end
    return SEL_ERR;
  endfunction

endpackage

// File: rtl/ysyx_25040129_clint_timer.sv
// Free-running 64-bit mtime counter advanced once every TICK_DIV clk cycles.
module ysyx_25040129_clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mtime
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic [63:0]      mtime_reg;
  logic             tick;

  assign tick  = (div_cnt_reg == DIV_W'(TICK_DIV - 1));
  assign mtime = mtime_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      mtime_reg   <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
      mtime_reg   <= mtime_reg + 64'd1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_25040129_clint.sv
// Read-only CLINT mtime responder: single-beat AR/R handshake, two-word decode,
// and a high-word shadow so a lo-then-hi read pair sees one coherent sample.
module ysyx_25040129_clint
  import ysyx_25040129_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rtc_araddr,
  input  logic        rtc_arvalid,
  output logic        rtc_arready,
  output logic [31:0] rtc_rdata,
  output logic [1:0]  rtc_rresp,
  output logic        rtc_rvalid,
  input  logic        rtc_rready
);

  clint_state_e state_reg, state_next;
  logic [31:0]  rdata_reg, rdata_next;
  logic [1:0]   rresp_reg, rresp_next;
  logic [31:0]  shadow_hi_reg, shadow_hi_next;
  logic         shadow_valid_reg, shadow_valid_next;

  logic [63:0]  mtime;
  logic [31:0]  offset;
  clint_sel_e   sel;
  logic         ar_fire;

  ysyx_25040129_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .mtime (mtime)
  );

  assign offset  = rtc_araddr - RTC_PORT_ADDR;
  assign sel     = decode_offset(offset);
  assign ar_fire = rtc_arvalid && rtc_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      rdata_reg        <= '0;
      rresp_reg        <= OKAY;
      shadow_hi_reg    <= '0;
      shadow_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rdata_reg        <= rdata_next;
      rresp_reg        <= rresp_next;
      shadow_hi_reg    <= shadow_hi_next;
      shadow_valid_reg <= shadow_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ar_fire)    state_next = ST_RESP;
      ST_RESP: if (rtc_rready) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Response capture uses mtime as seen in the handshake cycle, i.e. before
  // that edge's increment. Error reads leave the shadow untouched.
  always_comb begin
    rdata_next        = rdata_reg;
    rresp_next        = rresp_reg;
    shadow_hi_next    = shadow_hi_reg;
    shadow_valid_next = shadow_valid_reg;
    if (ar_fire) begin
      case (sel)
        SEL_LO: begin
          rdata_next        = mtime[31:0];
          rresp_next        = OKAY;
          shadow_hi_next    = mtime[63:32];
          shadow_valid_next = 1'b1;
        end
        SEL_HI: begin
          rdata_next        = shadow_valid_reg ? shadow_hi_reg : mtime[63:32];
          rresp_next        = OKAY;
          shadow_valid_next = 1'b0;
        end
        default: begin
          rdata_next = '0;
          rresp_next = SLVERR;
        end
      endcase
    end
  end

  assign rtc_arready = (state_reg == ST_IDLE) && !rst;
  assign rtc_rvalid  = (state_reg == ST_RESP) && !rst;
  assign rtc_rdata   = rst ? 32'h0 : rdata_reg;
  assign rtc_rresp   = rst ? OKAY  : rresp_reg;

endmodule

// File: tb/tb_ysyx_25040129_clint.sv
// Scoreboard bench: two CLINT instances (TICK_DIV=1 and 4), expected reads
// computed from elapsed cycles and the shadow rules, checked by a monitor.
module tb_ysyx_25040129_clint;
  import ysyx_25040129_clint_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];

  ysyx_25040129_clint #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst[0]), .rtc_araddr(araddr[0]), .rtc_arvalid(arvalid[0]),
    .rtc_arready(arready[0]), .rtc_rdata(rdata[0]), .rtc_rresp(rresp[0]),
    .rtc_rvalid(rvalid[0]), .rtc_rready(rready[0])
  );

  ysyx_25040129_clint #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst[1]), .rtc_araddr(araddr[1]), .rtc_arvalid(arvalid[1]),
    .rtc_arready(arready[1]), .rtc_rdata(rdata[1]), .rtc_rresp(rresp[1]),
    .rtc_rvalid(rvalid[1]), .rtc_rready(rready[1])
  );

  int div_of [2] = '{1, 4};
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mtime = base_val + elapsed cycles / TICK_DIV.
  logic [63:0] base_val [2];
  int          base_cyc [2];
  logic [31:0] sh_hi    [2];
  logic        sh_v     [2];
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  logic [63:0] force_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] model_mtime(input int inst, input int c);
    return base_val[inst] + 64'((c - base_cyc[inst]) / div_of[inst]);
  endfunction

  function automatic logic [33:0] model_read(input int inst, input logic [31:0] addr, input int c);
    logic [31:0] off;
    logic [63:0] m;
    logic [31:0] d;
    off = addr - RTC_PORT_ADDR;
    m   = model_mtime(inst, c);
    if (off == 32'd0) begin
      sh_hi[inst] = m[63:32];
      sh_v[inst]  = 1'b1;
      return {OKAY, m[31:0]};
    end else if (off == 32'd4) begin
      d = sh_v[inst] ? sh_hi[inst] : m[63:32];
      sh_v[inst] = 1'b0;
      return {OKAY, d};
    end
    return {SLVERR, 32'h0};
  endfunction

  // Enters at a step point; leaves at the negedge of the first cycle after release.
  task automatic do_reset(input int inst, input int n);
    rst[inst] = 1'b1; arvalid[inst] = 1'b0; rready[inst] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_arready", 64'(arready[inst]), 64'd0);
      chk("rst_rvalid",  64'(rvalid[inst]),  64'd0);
      chk("rst_rdata",   64'(rdata[inst]),   64'd0);
      chk("rst_rresp",   64'(rresp[inst]),   64'(OKAY));
      step();
    end
    rst[inst] = 1'b0;
    base_val[inst] = 64'd0; base_cyc[inst] = cyc;
    sh_hi[inst] = 32'd0; sh_v[inst] = 1'b0;
    if (inst == 0) q0.delete(); else q1.delete();
    @(negedge clk);
    chk("post_rst_arready", 64'(arready[inst]), 64'd1);
    chk("post_rst_rvalid",  64'(rvalid[inst]),  64'd0);
  endtask

  task automatic wait_until(input int inst, input int k);
    step();
    while (cyc - base_cyc[inst] < k) step();
  endtask

  task automatic set_mtime(input logic [63:0] v);
    force_val = v;
    force dut0.u_timer.mtime_reg = force_val;
    release dut0.u_timer.mtime_reg;
    base_val[0] = v; base_cyc[0] = cyc;
  endtask

  // Starts at a step point in IDLE, returns at a step point back in IDLE.
  task automatic do_read(input int inst, input logic [31:0] addr, input int stall);
    logic [33:0] e;
    rready[inst] = (stall == 0);
    araddr[inst] = addr; arvalid[inst] = 1'b1;
    e = model_read(inst, addr, cyc);
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    chk("arready_idle", 64'(arready[inst]), 64'd1);
    step();
    arvalid[inst] = 1'b0; araddr[inst] = $urandom;
    @(negedge clk);
    chk("rvalid_latency", 64'(rvalid[inst]), 64'd1);
    chk("arready_resp",   64'(arready[inst]), 64'd0);
    if (stall > 0) begin
      for (int k = 1; k < stall; k++) begin
        step();
        @(negedge clk);
        chk("stall_rvalid",  64'(rvalid[inst]),  64'd1);
        chk("stall_rdata",   64'(rdata[inst]),   64'(e[31:0]));
        chk("stall_rresp",   64'(rresp[inst]),   64'(e[33:32]));
        chk("stall_arready", 64'(arready[inst]), 64'd0);
      end
      step();
      rready[inst] = 1'b1;
      @(negedge clk);
    end
    step();
  endtask

  // Monitor: every completed R handshake pops one expected response.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i] === 1'b1 && rready[i] === 1'b1) begin
        logic [33:0] e;
        logic        empty;
        empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp inst=%0d: got data 0x%0h resp %0d, required no response",
                   i, rdata[i], rresp[i]);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          $display("read inst=%0d data=0x%08h resp=%0d exp_data=0x%08h exp_resp=%0d",
                   i, rdata[i], rresp[i], e[31:0], e[33:32]);
          chk("mon_rdata", 64'(rdata[i]), 64'(e[31:0]));
          chk("mon_rresp", 64'(rresp[i]), 64'(e[33:32]));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] addr_tbl [8];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; arvalid[i] = 1'b0; araddr[i] = 32'h0; rready[i] = 1'b1;
      base_val[i] = 64'd0; base_cyc[i] = 0; sh_hi[i] = 32'd0; sh_v[i] = 1'b0;
    end
    force_val = 64'd0;
    step();

    // TICK_DIV=1: handshake in cycle 10 reads 10.
    do_reset(0, 3);
    wait_until(0, 10);
    do_read(0, RTC_PORT_ADDR, 0);

    // Coherent lo/hi pair across a carry.
    set_mtime(64'h0000_0001_FFFF_FFFF);
    do_read(0, RTC_PORT_ADDR, 0);
    do_read(0, RTC_PORT_ADDR + 32'd4, 0);

    // Error offsets, then live high word.
    do_read(0, RTC_PORT_ADDR + 32'd8, 0);
    do_read(0, RTC_PORT_ADDR + 32'd2, 0);
    do_read(0, RTC_PORT_ADDR + 32'd4, 0);

    // Error reads between a lo/hi pair must not disturb the shadow.
    set_mtime(64'h0000_0001_FFFF_FFF8);
    do_read(0, RTC_PORT_ADDR, 0);
    do_read(0, RTC_PORT_ADDR + 32'd8, 0);
    do_read(0, RTC_PORT_ADDR + 32'd2, 0);
    for (int k = 0; k < 8; k++) step();
    do_read(0, RTC_PORT_ADDR + 32'd4, 0);
    do_read(0, RTC_PORT_ADDR + 32'd4, 0);

    // Two lo reads: the later one sets the shadow.
    set_mtime(64'h0000_0004_FFFF_FFFA);
    do_read(0, RTC_PORT_ADDR, 0);
    for (int k = 0; k < 8; k++) step();
    do_read(0, RTC_PORT_ADDR, 0);
    set_mtime(64'h0000_0009_0000_0000);
    do_read(0, RTC_PORT_ADDR + 32'd4, 0);

    // Backpressure for 5 cycles; the following read shows mtime kept counting.
    do_read(0, RTC_PORT_ADDR, 5);
    do_read(0, RTC_PORT_ADDR, 0);

    // Randomized traffic.
    addr_tbl[0] = RTC_PORT_ADDR;          addr_tbl[1] = RTC_PORT_ADDR + 32'd4;
    addr_tbl[2] = RTC_PORT_ADDR + 32'd8;  addr_tbl[3] = RTC_PORT_ADDR + 32'd2;
    addr_tbl[4] = RTC_PORT_ADDR - 32'd4;  addr_tbl[5] = RTC_PORT_ADDR + 32'd1;
    addr_tbl[6] = RTC_PORT_ADDR + 32'd4;  addr_tbl[7] = RTC_PORT_ADDR;
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      if (it % 10 == 0)
        set_mtime({29'd0, 3'($urandom_range(0, 7)), 32'hFFFF_FFF0 + 32'($urandom_range(0, 12))});
      a = ($urandom_range(0, 9) == 0) ? $urandom : addr_tbl[$urandom_range(0, 7)];
      do_read(0, a, $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    // TICK_DIV=4: handshake in cycle 13 reads 3; reset drops the response.
    do_reset(1, 2);
    wait_until(1, 13);
    rready[1] = 1'b0;
    araddr[1] = RTC_PORT_ADDR; arvalid[1] = 1'b1;
    begin
      logic [33:0] e4;
      e4 = model_read(1, RTC_PORT_ADDR, cyc);
      @(negedge clk);
      chk("div4_arready", 64'(arready[1]), 64'd1);
      step();
      arvalid[1] = 1'b0;
      @(negedge clk);
      chk("div4_rvalid", 64'(rvalid[1]), 64'd1);
      chk("div4_rdata",  64'(rdata[1]),  64'(e4[31:0]));
      chk("div4_rdata3", 64'(rdata[1]),  64'd3);
    end
    step();
    do_reset(1, 1);
    wait_until(1, 1);
    do_read(1, RTC_PORT_ADDR, 0);

    for (int k = 0; k < 4; k++) step();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
